// File: rtl/qeciphy_traffic_gen_chk.sv
// qeciphy_traffic_gen_chk
//
// Purpose:
//   Link test engine. A generator drives a known dataset out of an AXI-Stream
//   master port while a checker consumes the returning stream and compares each
//   beat against its own independent copy of the generator. Two datasets are
//   available: an incrementing beat counter and an xorshift32 pseudo-random
//   sequence. A watchdog ends a test that stops making progress.
//
// Parameters:
//   DATA_WIDTH      beat width (32, 64, 128 or 256)
//   LEN_W           width of the sequence-length input
//   TIMEOUT_CYCLES  maximum number of RUN cycles before the test is abandoned
//
// Ports:
//   ACLK, ARST                 clock, asynchronous active-high reset
//   START                      single-cycle start pulse (ignored while running)
//   MODE                       0 = counter dataset, 1 = pseudo-random dataset
//   SEQ_LEN                    beats per test
//   SEED                       pseudo-random seed (0 behaves as 1)
//   TX_TDATA/TVALID/TREADY     generator master stream
//   RX_TDATA/TVALID/TREADY     checker slave stream
//   BUSY                       test running
//   DONE, PASS, TIMEOUT        test result, held until the next START
//   ERR_CNT                    saturating mismatch count
//   FIRST_ERR_IDX              index of first mismatching beat, all-ones if none

module qeciphy_traffic_gen_chk #(
    parameter int DATA_WIDTH     = 64,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic                  ACLK,
    input  logic                  ARST,
    input  logic                  START,
    input  logic                  MODE,
    input  logic [LEN_W-1:0]      SEQ_LEN,
    input  logic [31:0]           SEED,
    output logic [DATA_WIDTH-1:0] TX_TDATA,
    output logic                  TX_TVALID,
    input  logic                  TX_TREADY,
    input  logic [DATA_WIDTH-1:0] RX_TDATA,
    input  logic                  RX_TVALID,
    output logic                  RX_TREADY,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic                  TIMEOUT,
    output logic [15:0]           ERR_CNT,
    output logic [LEN_W-1:0]      FIRST_ERR_IDX
);

    localparam int          LANES    = DATA_WIDTH / 32;
    localparam logic [31:0] CYC_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  mode_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      tx_cnt;
    logic [LEN_W-1:0]      rx_cnt;
    logic [LEN_W-1:0]      rx_cnt_inc;
    logic [31:0]           tx_x;
    logic [31:0]           rx_x;
    logic [31:0]           cyc_cnt;
    logic [31:0]           seed_init;

    logic [DATA_WIDTH-1:0] tx_rand;
    logic [DATA_WIDTH-1:0] rx_rand;
    logic [DATA_WIDTH-1:0] tx_beat;
    logic [DATA_WIDTH-1:0] rx_expect;

    logic                  start_go;
    logic                  tx_fire;
    logic                  rx_fire;
    logic                  rx_bad;
    logic                  run_done;
    logic                  run_timeout;
    logic                  err_hit;
    logic [15:0]           err_next;

    // One xorshift32 step.
    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // A pseudo-random beat is LANES successive xorshift outputs starting from
    // state x, earliest output in the least significant lane. The top lane is
    // therefore also the generator state to use for the following beat.
    function automatic logic [DATA_WIDTH-1:0] rand_beat(input logic [31:0] x);
        logic [DATA_WIDTH-1:0] b;
        logic [31:0]           s;
        b = '0;
        s = x;
        for (int k = 0; k < LANES; k++) begin
            s            = xorshift32(s);
            b[k*32 +: 32] = s;
        end
        return b;
    endfunction

    // The generator and checker each keep their own beat index and xorshift
    // state, so the checker's expectation depends only on what it has accepted,
    // never on how far the transmitter has got.
    assign tx_rand   = rand_beat(tx_x);
    assign rx_rand   = rand_beat(rx_x);
    assign tx_beat   = mode_q ? tx_rand : DATA_WIDTH'(tx_cnt);
    assign rx_expect = mode_q ? rx_rand : DATA_WIDTH'(rx_cnt);
    assign seed_init = (SEED == 32'd0) ? 32'd1 : SEED;

    // Stream handshakes. TX data comes purely from registers that only move
    // on an accepted beat, so it cannot change while the sink is stalling.
    assign TX_TVALID = (state == S_RUN) && (tx_cnt != len_q);
    assign TX_TDATA  = TX_TVALID ? tx_beat : '0;
    assign RX_TREADY = (state != S_IDLE);
    assign BUSY      = (state == S_RUN);
    assign tx_fire   = TX_TVALID && TX_TREADY;
    assign rx_fire   = RX_TVALID && RX_TREADY;
    assign rx_bad    = rx_fire && (RX_TDATA != rx_expect);

    // Test control: a START is honoured only outside RUN. A run ends on the
    // accept of the last expected beat, or on the watchdog; a clean finish
    // wins if both land in the same cycle. Beats arriving after the test has
    // finished are unexpected and are always counted as errors.
    assign start_go    = START && (state != S_RUN);
    assign rx_cnt_inc  = rx_cnt + 1'b1;
    assign run_done    = (state == S_RUN) && rx_fire && (rx_cnt_inc == len_q);
    assign run_timeout = (state == S_RUN) && !run_done && (cyc_cnt == CYC_LAST);
    assign err_hit     = ((state == S_RUN) && rx_bad) || ((state == S_FIN) && rx_fire);
    assign err_next    = (err_hit && (ERR_CNT != 16'hFFFF)) ? ERR_CNT + 16'd1 : ERR_CNT;

    // State register.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A zero-length test goes straight to FIN.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_FIN: begin
                if (START) begin
                    state_next = (SEQ_LEN == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (run_done || run_timeout) begin
                    state_next = S_FIN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and result registers. START reloads everything for a fresh
    // test; in RUN the TX and RX sides advance independently on their own
    // handshakes, and the result flags are captured on the way into FIN.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            mode_q        <= 1'b0;
            len_q         <= '0;
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            tx_x          <= '0;
            rx_x          <= '0;
            cyc_cnt       <= '0;
            ERR_CNT       <= '0;
            FIRST_ERR_IDX <= '1;
            DONE          <= 1'b0;
            PASS          <= 1'b0;
            TIMEOUT       <= 1'b0;
        end else if (start_go) begin
            mode_q        <= MODE;
            len_q         <= SEQ_LEN;
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            tx_x          <= seed_init;
            rx_x          <= seed_init;
            cyc_cnt       <= '0;
            ERR_CNT       <= '0;
            FIRST_ERR_IDX <= '1;
            DONE          <= (SEQ_LEN == '0);
            PASS          <= (SEQ_LEN == '0);
            TIMEOUT       <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    cyc_cnt <= cyc_cnt + 32'd1;
                    ERR_CNT <= err_next;
                    if (tx_fire) begin
                        tx_cnt <= tx_cnt + 1'b1;
                        tx_x   <= tx_rand[DATA_WIDTH-1 -: 32];
                    end
                    if (rx_fire) begin
                        rx_cnt <= rx_cnt_inc;
                        rx_x   <= rx_rand[DATA_WIDTH-1 -: 32];
                    end
                    if (rx_bad && (FIRST_ERR_IDX == '1)) begin
                        FIRST_ERR_IDX <= rx_cnt;
                    end
                    if (run_done) begin
                        DONE <= 1'b1;
                        PASS <= (err_next == 16'd0);
                    end else if (run_timeout) begin
                        DONE    <= 1'b1;
                        PASS    <= 1'b0;
                        TIMEOUT <= 1'b1;
                    end
                end
                S_FIN: begin
                    ERR_CNT <= err_next;
                    if (rx_fire) begin
                        PASS <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qeciphy_traffic_gen_chk.sv
// Directed bench for qeciphy_traffic_gen_chk. A 128-bit instance is run in
// TX->RX loopback (optionally with random stalls or a corrupted beat, or with
// the RX side driven by hand); a 32-bit instance with a short watchdog covers
// the timeout path.

module tb_qeciphy_traffic_gen_chk;

    localparam int DW = 128;
    localparam int LW = 16;

    int checks = 0;
    int errors = 0;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic arst;

    // main instance
    logic          start;
    logic          mode;
    logic [LW-1:0] seq_len;
    logic [31:0]   seed;
    logic [DW-1:0] tx_tdata;
    logic          tx_tvalid;
    logic          tx_tready;
    logic [DW-1:0] rx_tdata;
    logic          rx_tvalid;
    logic          rx_tready;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [15:0]   err_cnt;
    logic [LW-1:0] first_err_idx;

    // loopback control
    logic          loop_en;
    logic          stall_en;
    logic          stall;
    logic          corrupt_en;
    logic          man_tx_ready;
    logic          man_rx_valid;
    logic [DW-1:0] man_rx_data;

    // timeout instance
    logic          t_start;
    logic [LW-1:0] t_seq_len;
    logic [31:0]   t_tx_tdata;
    logic          t_tx_tvalid;
    logic          t_rx_tready;
    logic          t_busy;
    logic          t_done;
    logic          t_pass;
    logic          t_timeout;
    logic [15:0]   t_err_cnt;
    logic [LW-1:0] t_first_err_idx;

    // monitor state
    logic [DW-1:0] beats [0:4095];
    int            nbeats;
    logic          held_valid;
    logic [DW-1:0] held_data;

    assign tx_tready = loop_en ? (rx_tready & ~stall) : man_tx_ready;
    assign rx_tvalid = loop_en ? (tx_tvalid & ~stall) : man_rx_valid;
    assign rx_tdata  = loop_en ? (tx_tdata ^ ((corrupt_en && nbeats == 5) ? 128'd1 : 128'd0))
                               : man_rx_data;

    qeciphy_traffic_gen_chk #(
        .DATA_WIDTH(DW), .LEN_W(LW), .TIMEOUT_CYCLES(10000)
    ) dut (
        .ACLK(aclk), .ARST(arst), .START(start), .MODE(mode), .SEQ_LEN(seq_len), .SEED(seed),
        .TX_TDATA(tx_tdata), .TX_TVALID(tx_tvalid), .TX_TREADY(tx_tready),
        .RX_TDATA(rx_tdata), .RX_TVALID(rx_tvalid), .RX_TREADY(rx_tready),
        .BUSY(busy), .DONE(done), .PASS(pass), .TIMEOUT(timeout),
        .ERR_CNT(err_cnt), .FIRST_ERR_IDX(first_err_idx)
    );

    qeciphy_traffic_gen_chk #(
        .DATA_WIDTH(32), .LEN_W(LW), .TIMEOUT_CYCLES(100)
    ) dut_to (
        .ACLK(aclk), .ARST(arst), .START(t_start), .MODE(1'b0), .SEQ_LEN(t_seq_len), .SEED(32'd0),
        .TX_TDATA(t_tx_tdata), .TX_TVALID(t_tx_tvalid), .TX_TREADY(1'b1),
        .RX_TDATA(32'd0), .RX_TVALID(1'b0), .RX_TREADY(t_rx_tready),
        .BUSY(t_busy), .DONE(t_done), .PASS(t_pass), .TIMEOUT(t_timeout),
        .ERR_CNT(t_err_cnt), .FIRST_ERR_IDX(t_first_err_idx)
    );

    // Random sink stalls, changed on the falling edge.
    always @(negedge aclk) begin
        stall = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    // Record every accepted TX beat and check TX data holds across stalls.
    always @(posedge aclk) begin
        if (!arst && held_valid && tx_tvalid) begin
            checks++;
            assert (tx_tdata === held_data) else begin
                errors++;
                $error("[TB] FAIL tx_stable observed=%0h expected=%0h", tx_tdata, held_data);
            end
        end
        if (!arst && tx_tvalid && tx_tready) begin
            if (nbeats < 4096) beats[nbeats] = tx_tdata;
            nbeats++;
        end
        held_valid = tx_tvalid && !tx_tready;
        held_data  = tx_tdata;
    end

    // Global safety net.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called on a falling edge; pulses START for one cycle.
    task automatic applyStimulus(input logic m, input logic [LW-1:0] len, input logic [31:0] sd);
        mode    = m;
        seq_len = len;
        seed    = sd;
        start   = 1'b1;
        @(negedge aclk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!done && n < max_cycles) begin
            @(negedge aclk);
            n++;
        end
        checkOutput(tag, done, 1'b1);
    endtask

    initial begin
        int bad;
        int n;
        arst = 1'b1; start = 1'b0; mode = 1'b0; seq_len = '0; seed = '0;
        loop_en = 1'b0; stall_en = 1'b0; stall = 1'b0; corrupt_en = 1'b0;
        man_tx_ready = 1'b0; man_rx_valid = 1'b0; man_rx_data = '0;
        t_start = 1'b0; t_seq_len = '0;
        nbeats = 0; held_valid = 1'b0; held_data = '0;

        // reset state
        repeat (3) @(negedge aclk);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_pass", pass, 1'b0);
        checkOutput("rst_timeout", timeout, 1'b0);
        checkOutput("rst_err", err_cnt, 16'd0);
        checkOutput("rst_first", first_err_idx, 16'hFFFF);
        checkOutput("rst_tvalid", tx_tvalid, 1'b0);
        checkOutput("rst_tdata", tx_tdata, 128'd0);
        checkOutput("rst_rready", rx_tready, 1'b0);
        arst = 1'b0;
        repeat (2) @(negedge aclk);
        checkOutput("idle_no_traffic", tx_tvalid, 1'b0);

        // counter loopback, 2048 beats; a START mid-run must be ignored
        $display("[TB] counter loopback 2048");
        loop_en = 1'b1; nbeats = 0;
        applyStimulus(1'b0, 16'd2048, 32'd0);
        checkOutput("run_busy", busy, 1'b1);
        repeat (20) @(negedge aclk);
        applyStimulus(1'b0, 16'd5, 32'd0);
        checkOutput("start_ignored_busy", busy, 1'b1);
        waitDone("cnt_done", 3000);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (beats[i] !== 128'(i)) bad++;
        checkOutput("cnt_nbeats", nbeats, 2048);
        checkOutput("cnt_bad_beats", bad, 0);
        checkOutput("cnt_beat0", beats[0], 128'd0);
        checkOutput("cnt_beat2047", beats[2047], 128'd2047);
        checkOutput("cnt_pass", pass, 1'b1);
        checkOutput("cnt_err", err_cnt, 16'd0);
        checkOutput("cnt_first", first_err_idx, 16'hFFFF);
        checkOutput("cnt_busy_fin", busy, 1'b0);
        checkOutput("cnt_rready_fin", rx_tready, 1'b1);

        // pseudo-random loopback, seed 0, random stalls
        $display("[TB] random loopback with stalls");
        nbeats = 0; stall_en = 1'b1;
        applyStimulus(1'b1, 16'd20, 32'd0);
        waitDone("rnd_done", 500);
        stall_en = 1'b0;
        checkOutput("rnd_nbeats", nbeats, 20);
        checkOutput("rnd_lane0", beats[0][31:0], 32'h0004_2021);
        checkOutput("rnd_lane1", beats[0][63:32], 32'h0408_0601);
        checkOutput("rnd_pass", pass, 1'b1);
        checkOutput("rnd_err", err_cnt, 16'd0);

        // bit 0 of beat 5 inverted on the return path
        $display("[TB] corrupted beat 5");
        nbeats = 0; corrupt_en = 1'b1;
        applyStimulus(1'b0, 16'd16, 32'd0);
        waitDone("cor_done", 200);
        corrupt_en = 1'b0;
        checkOutput("cor_nbeats", nbeats, 16);
        checkOutput("cor_err", err_cnt, 16'd1);
        checkOutput("cor_first", first_err_idx, 16'd5);
        checkOutput("cor_pass", pass, 1'b0);

        // watchdog: nothing returns, 100-cycle limit
        $display("[TB] timeout");
        t_seq_len = 16'd200; t_start = 1'b1;
        @(negedge aclk);
        t_start = 1'b0;
        n = 0;
        while (t_busy && n < 300) begin
            n++;
            @(negedge aclk);
        end
        checkOutput("to_run_cycles", n, 100);
        checkOutput("to_timeout", t_timeout, 1'b1);
        checkOutput("to_pass", t_pass, 1'b0);
        checkOutput("to_tvalid", t_tx_tvalid, 1'b0);
        checkOutput("to_err", t_err_cnt, 16'd0);

        // reset in the middle of a run, then a fresh short test
        $display("[TB] reset mid-run");
        nbeats = 0;
        applyStimulus(1'b0, 16'd100, 32'd0);
        n = 0;
        while (nbeats < 10 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("mid_reached10", nbeats >= 10, 1'b1);
        arst = 1'b1;
        @(negedge aclk);
        checkOutput("mid_busy", busy, 1'b0);
        checkOutput("mid_done", done, 1'b0);
        checkOutput("mid_first", first_err_idx, 16'hFFFF);
        checkOutput("mid_tvalid", tx_tvalid, 1'b0);
        checkOutput("mid_rready", rx_tready, 1'b0);
        checkOutput("mid_to_timeout", t_timeout, 1'b0);
        arst = 1'b0;
        repeat (3) @(negedge aclk);
        checkOutput("post_rst_idle", tx_tvalid, 1'b0);
        nbeats = 0;
        applyStimulus(1'b0, 16'd4, 32'd0);
        waitDone("new_done", 50);
        checkOutput("new_nbeats", nbeats, 4);
        checkOutput("new_beat0", beats[0], 128'd0);
        checkOutput("new_beat3", beats[3], 128'd3);
        checkOutput("new_pass", pass, 1'b1);

        // zero-length test, then an unsolicited RX beat
        $display("[TB] zero length");
        loop_en = 1'b0; man_tx_ready = 1'b1; man_rx_valid = 1'b0; nbeats = 0;
        applyStimulus(1'b0, 16'd0, 32'd0);
        checkOutput("zero_done", done, 1'b1);
        checkOutput("zero_pass", pass, 1'b1);
        checkOutput("zero_busy", busy, 1'b0);
        checkOutput("zero_tvalid", tx_tvalid, 1'b0);
        man_rx_valid = 1'b1; man_rx_data = 128'd0;
        @(negedge aclk);
        man_rx_valid = 1'b0;
        checkOutput("extra_err", err_cnt, 16'd1);
        checkOutput("extra_pass", pass, 1'b0);
        checkOutput("extra_first", first_err_idx, 16'hFFFF);
        checkOutput("zero_nbeats", nbeats, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qeciphy_traffic_gen_chk.md
QECIPHY_TRAFFIC_GEN_CHK -- requirements
Module: qeciphy_traffic_gen_chk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, AXI-Stream beat width; legal values 32, 64, 128, 256.
REQ-002 SHALL have parameter LEN_W, default 16, width of the sequence-length input.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 131072, RUN-state watchdog limit in ACLK cycles.
REQ-004 SHALL have port ACLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port ARST  input  1  reset, asynchronous assert, active-high.
REQ-006 SHALL have port START  input  1  single-cycle start pulse.
REQ-007 SHALL have port MODE  input  1  0 = counter dataset, 1 = pseudo-random dataset.
REQ-008 SHALL have port SEQ_LEN  input  LEN_W  number of beats per test.
REQ-009 SHALL have port SEED  input  32  pseudo-random seed.
REQ-010 SHALL have ports TX_TDATA/TX_TVALID  output  DATA_WIDTH/1, and TX_TREADY  input  1  generator AXI-Stream master.
REQ-011 SHALL have ports RX_TDATA/RX_TVALID  input  DATA_WIDTH/1, and RX_TREADY  output  1  checker AXI-Stream slave.
REQ-012 SHALL have outputs BUSY 1, DONE 1, PASS 1, TIMEOUT 1, ERR_CNT 16, FIRST_ERR_IDX LEN_W  test status.

Function
REQ-013 SHALL implement FSM IDLE, RUN, FIN; reset state IDLE.
REQ-014 SHALL, on START in IDLE or FIN: latch MODE, SEQ_LEN, SEED; clear tx_cnt, rx_cnt, cycle counter, ERR_CNT, TIMEOUT, DONE; set FIRST_ERR_IDX to all-ones; go to RUN, or to FIN with PASS=1 if SEQ_LEN=0.
REQ-015 SHALL ignore START while in RUN.
REQ-016 SHALL assert TX_TVALID from the first cycle of RUN until tx_cnt equals the latched length; beat completes on TX_TVALID && TX_TREADY; tx_cnt then increments.
REQ-017 SHALL hold TX_TDATA stable while TX_TVALID=1 and TX_TREADY=0.
REQ-018 SHALL generate beat i in counter mode as i zero-extended to DATA_WIDTH.
REQ-019 SHALL generate in random mode by xorshift32 (x^=x<<13; x^=x>>17; x^=x<<5), seed 0 replaced by 1; beat occupies DATA_WIDTH/32 successive outputs, lane 0 = earliest (bits 31:0).
REQ-020 SHALL derive expected RX data from an independent generator copy advanced only on RX accept.
REQ-021 SHALL drive RX_TREADY=1 in RUN and FIN, 0 in IDLE.
REQ-022 SHALL, on RX accept in RUN with data != expected: increment ERR_CNT (saturate at 0xFFFF); if FIRST_ERR_IDX is all-ones, load rx_cnt.
REQ-023 SHALL transition RUN -> FIN the cycle after the accept making rx_cnt equal the latched length; DONE=1 and PASS=(ERR_CNT==0) registered on entry.
REQ-024 SHALL count RX beats accepted in FIN as errors (ERR_CNT increment, PASS cleared) without updating FIRST_ERR_IDX.
REQ-025 SHALL, when the RUN cycle counter reaches TIMEOUT_CYCLES, enter FIN with TIMEOUT=1, PASS=0, TX_TVALID=0.
REQ-026 SHALL assert BUSY exactly while in RUN; DONE and PASS held in FIN until next START.
REQ-027 SHALL handle simultaneous TX and RX accepts in the same cycle independently.

Reset
REQ-028 SHALL on ARST force IDLE and all outputs to 0 except FIRST_ERR_IDX all-ones, including mid-RUN; no partial beat resumes after release.
REQ-029 SHALL require a START after reset release before any traffic.

Verification
REQ-030 TX looped to RX, MODE=0, SEQ_LEN=2048, TX_TREADY=1 -> 2048 beats 0..2047, DONE=1, PASS=1, ERR_CNT=0.
REQ-031 Loopback, MODE=1, SEED=0, DATA_WIDTH=128, random TX_TREADY stalls -> lane 0 of beat 0 = xorshift32(1), TX_TDATA stable under stall, PASS=1.
REQ-032 Loopback with bit 0 of beat 5 inverted, SEQ_LEN=16 -> ERR_CNT=1, FIRST_ERR_IDX=5, PASS=0.
REQ-033 RX_TVALID held 0, TIMEOUT_CYCLES=100 -> FIN after 100 RUN cycles, TIMEOUT=1, PASS=0.
REQ-034 ARST asserted after 10 beats, then START with SEQ_LEN=4 -> outputs reset, new test beats 0..3, PASS=1.
REQ-035 START with SEQ_LEN=0 -> FIN next cycle, PASS=1, no TX beats; extra RX beat in FIN -> ERR_CNT=1, PASS=0.
